// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS/CTRL bit positions, TX state encoding and the default baud divider.
package mmio_uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CLKDIV = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int STATUS_BUSY      = 0;
  localparam int STATUS_FULL      = 1;
  localparam int STATUS_EMPTY     = 2;
  localparam int STATUS_OVF       = 3;
  localparam int STATUS_COUNT_LSB = 8;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_CLR_OVF = 1;

  localparam logic [15:0] CLKDIV_RESET_DEFAULT = 16'd867;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory style load/store bus shared by the CPU, data memory and the UART.
interface mmio_uart_tx_if;

  logic [31:0] addr;
  logic [31:0] write_value;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] read_value;

  modport master (output addr, write_value, write_enable, read_enable, input read_value);
  modport slave  (input addr, write_value, write_enable, read_enable, output read_value);

endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous byte FIFO feeding the transmitter. A push into a full FIFO is
// still accepted when a pop happens on the same edge.
module mmio_uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, control registers, baud
// counter and the frame FSM. Bytes are queued in mmio_uart_tx_fifo.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] CLKDIV_RESET = CLKDIV_RESET_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  mmio_uart_tx_if.slave bus,
  output logic          sel,
  output logic          tx,
  output logic          irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] clkdiv_q, clkdiv_d;
  logic        enable_q, enable_d;
  logic        ovf_q, ovf_d;
  logic        tx_q, tx_d;
  logic        irq_q, irq_d;

  logic [1:0]    offset;
  logic          wr_en, push, push_ok, bit_end, empty_next;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_data;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status_word, read_word;
  logic          unused_bits;

  assign sel         = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign offset      = bus.addr[3:2];
  assign wr_en       = sel & bus.write_enable;
  assign push        = wr_en & (offset == REG_TXDATA);
  assign bit_end     = (baud_q == 16'd0);
  assign unused_bits = ^{bus.addr[1:0], bus.write_value[31:16]};

  mmio_uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.write_value[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Frame sequencing; the baud counter is reloaded from CLKDIV at every bit start.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    baud_d   = baud_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_q && !fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          bitcnt_d = 3'd0;
          baud_d   = clkdiv_q;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          baud_d  = clkdiv_q;
          state_d = ST_DATA;
        end else baud_d = baud_q - 16'd1;
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_d   = clkdiv_q;
          shift_d  = shift_q >> 1;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = ST_STOP;
        end else baud_d = baud_q - 16'd1;
      end
      ST_STOP: begin
        if (bit_end) state_d = ST_IDLE;
        else         baud_d  = baud_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    tx_d = (state_d == ST_START) ? 1'b0 :
           (state_d == ST_DATA)  ? shift_d[0] : 1'b1;
  end

  // Register writes; an overflow set wins over a same-cycle clear.
  always_comb begin
    clkdiv_d = clkdiv_q;
    enable_d = enable_q;
    ovf_d    = ovf_q;
    if (wr_en && offset == REG_CLKDIV) clkdiv_d = bus.write_value[15:0];
    if (wr_en && offset == REG_CTRL) begin
      enable_d = bus.write_value[CTRL_ENABLE];
      if (bus.write_value[CTRL_CLR_OVF]) ovf_d = 1'b0;
    end
    if (push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    push_ok    = push & (~fifo_full | fifo_pop);
    empty_next = (fifo_empty & ~push_ok) |
                 ((fifo_count == CW'(1)) & fifo_pop & ~push_ok);
    irq_d      = enable_d & empty_next & (state_d == ST_IDLE);
  end

  always_comb begin
    status_word               = 32'h0;
    status_word[STATUS_BUSY]  = (state_q != ST_IDLE);
    status_word[STATUS_FULL]  = fifo_full;
    status_word[STATUS_EMPTY] = fifo_empty;
    status_word[STATUS_OVF]   = ovf_q;
    status_word = status_word | ((32'(fifo_count) << STATUS_COUNT_LSB) & 32'h0000_0F00);
    read_word = 32'h0;
    if (sel && bus.read_enable) begin
      case (offset)
        REG_STATUS: read_word = status_word;
        REG_CLKDIV: read_word = {16'h0, clkdiv_q};
        REG_CTRL:   read_word = {31'h0, enable_q};
        default:    read_word = 32'h0;
      endcase
    end
  end

  assign bus.read_value = read_word;
  assign tx  = tx_q;
  assign irq = irq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= 8'h0;
      bitcnt_q <= 3'd0;
      baud_q   <= 16'd0;
      clkdiv_q <= CLKDIV_RESET;
      enable_q <= 1'b1;
      ovf_q    <= 1'b0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      baud_q   <= baud_d;
      clkdiv_q <= clkdiv_d;
      enable_q <= enable_d;
      ovf_q    <= ovf_d;
      tx_q     <= tx_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a register/decode vector table plus
// hand-written serial frame, overflow and reset sequences.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'h0001_0000;
   localparam logic [31:0] A_TXDATA = BASE + 32'h0;
   localparam logic [31:0] A_STATUS = BASE + 32'h4;
   localparam logic [31:0] A_CLKDIV = BASE + 32'h8;
   localparam logic [31:0] A_CTRL   = BASE + 32'hC;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic sel, tx, irq;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic        re;
      logic [31:0] expRead;
      logic        expSel;
   } vec_t;

   vec_t vecs[17];

   mmio_uart_tx_if bus();

   mmio_uart_tx #(
      .BASE_ADDR    (BASE),
      .FIFO_DEPTH   (8),
      .CLKDIV_RESET (16'd867)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .sel (sel),
      .tx  (tx),
      .irq (irq)
   );

   // 10 ns system clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic setVec(input int idx, input string name, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input logic re, input logic [31:0] expRead, input logic expSel);
      vecs[idx].name    = name;
      vecs[idx].addr    = addr;
      vecs[idx].we      = we;
      vecs[idx].wdata   = wdata;
      vecs[idx].re      = re;
      vecs[idx].expRead = expRead;
      vecs[idx].expSel  = expSel;
   endtask

   // Drives one vector for one clock period and checks the combinational read path
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      bus.addr         = v.addr;
      bus.write_enable = v.we;
      bus.write_value  = v.wdata;
      bus.read_enable  = v.re;
      #1;
      checkOutput({v.name, "_read"}, 64'(bus.read_value), 64'(v.expRead));
      checkOutput({v.name, "_sel"}, 64'(sel), 64'(v.expSel));
   endtask

   // Called just after a falling edge; commits on the next rising edge, returns after the following falling edge
   task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
      bus.addr         = addr;
      bus.write_value  = data;
      bus.write_enable = 1'b1;
      bus.read_enable  = 1'b0;
      @(negedge clk);
      bus.write_enable = 1'b0;
   endtask

   task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
      bus.addr        = addr;
      bus.read_enable = 1'b1;
      #1;
      data = bus.read_value;
      bus.read_enable = 1'b0;
   endtask

   function automatic logic [9:0] frameBits(input logic [7:0] b);
      return {1'b1, b, 1'b0};
   endfunction

   initial begin
      logic [31:0] rd;
      logic [43:0] txB, busyB, expTxB, expBusyB;
      logic [62:0] txC, expC;
      logic [7:0]  bytesC [3];
      logic [9:0]  fr;
      logic        irqB, irqC63, irqC64, allHigh;
      int          idx;

      bus.addr         = 32'h0;
      bus.write_value  = 32'h0;
      bus.write_enable = 1'b0;
      bus.read_enable  = 1'b0;

      setVec(0,  "status_reset",  A_STATUS,         1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b1);
      setVec(1,  "clkdiv_reset",  A_CLKDIV,         1'b0, 32'h0,         1'b1, 32'd867,       1'b1);
      setVec(2,  "ctrl_reset",    A_CTRL,           1'b0, 32'h0,         1'b1, 32'h1,         1'b1);
      setVec(3,  "txdata_read",   A_TXDATA,         1'b0, 32'h0,         1'b1, 32'h0,         1'b1);
      setVec(4,  "clkdiv_rw_pre", A_CLKDIV,         1'b1, 32'hABCD_1234, 1'b1, 32'd867,       1'b1);
      setVec(5,  "clkdiv_new",    BASE + 32'hA,     1'b0, 32'h0,         1'b1, 32'h0000_1234, 1'b1);
      setVec(6,  "status_write",  A_STATUS,         1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b1);
      setVec(7,  "status_same",   A_STATUS,         1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b1);
      setVec(8,  "store_base10",  BASE + 32'h10,    1'b1, 32'h55,        1'b0, 32'h0,         1'b0);
      setVec(9,  "store_dmem",    32'h0000_0000,    1'b1, 32'h66,        1'b0, 32'h0,         1'b0);
      setVec(10, "load_base10",   BASE + 32'h10,    1'b0, 32'h0,         1'b1, 32'h0,         1'b0);
      setVec(11, "status_nopush", A_STATUS,         1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b1);
      setVec(12, "ctrl_rw_pre",   A_CTRL,           1'b1, 32'h0,         1'b1, 32'h1,         1'b1);
      setVec(13, "ctrl_off",      A_CTRL,           1'b0, 32'h0,         1'b1, 32'h0,         1'b1);
      setVec(14, "ctrl_write3",   A_CTRL,           1'b1, 32'h3,         1'b0, 32'h0,         1'b1);
      setVec(15, "ctrl_on",       A_CTRL,           1'b0, 32'h0,         1'b1, 32'h1,         1'b1);
      setVec(16, "read_disabled", A_CTRL,           1'b0, 32'h0,         1'b0, 32'h0,         1'b1);

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset_tx", 64'(tx), 64'(1'b1));
      checkOutput("reset_irq", 64'(irq), 64'(1'b0));
      rst = 1'b1;

      for (int i = 0; i < 17; i++) applyStimulus(vecs[i]);
      bus.write_enable = 1'b0;
      bus.read_enable  = 1'b0;

      // Single frame of 0x55 with 4 clocks per bit
      busWrite(A_CLKDIV, 32'd3);
      busWrite(A_TXDATA, 32'h55);
      checkOutput("irq_after_push", 64'(irq), 64'(1'b0));
      fr = frameBits(8'h55);
      for (int i = 0; i < 44; i++) begin
         expTxB[i]   = (i < 40) ? fr[i / 4] : 1'b1;
         expBusyB[i] = (i < 40);
      end
      bus.addr        = A_STATUS;
      bus.read_enable = 1'b1;
      irqB = 1'b0;
      for (int i = 0; i < 44; i++) begin
         @(negedge clk);
         #1;
         txB[i]   = tx;
         busyB[i] = bus.read_value[0];
         if (i == 40) irqB = irq;
      end
      bus.read_enable = 1'b0;
      checkOutput("frame_55_tx", 64'(txB), 64'(expTxB));
      checkOutput("frame_55_busy", 64'(busyB), 64'(expBusyB));
      checkOutput("frame_55_irq_end", 64'(irqB), 64'(1'b1));

      // Three back-to-back frames with 2 clocks per bit
      busWrite(A_CLKDIV, 32'd1);
      bytesC[0] = 8'h41;
      bytesC[1] = 8'h42;
      bytesC[2] = 8'h43;
      idx = 0;
      for (int f = 0; f < 3; f++) begin
         fr = frameBits(bytesC[f]);
         for (int b = 0; b < 20; b++) begin
            expC[idx] = fr[b / 2];
            idx++;
         end
         expC[idx] = 1'b1;
         idx++;
      end
      irqC63 = 1'b1;
      irqC64 = 1'b0;
      for (int i = 0; i < 65; i++) begin
         @(negedge clk);
         if (i < 3) begin
            bus.addr         = A_TXDATA;
            bus.write_value  = {24'h0, bytesC[i]};
            bus.write_enable = 1'b1;
         end else begin
            bus.write_enable = 1'b0;
         end
         #1;
         if (i >= 2) txC[i - 2] = tx;
         if (i == 63) irqC63 = irq;
         if (i == 64) irqC64 = irq;
      end
      checkOutput("frames_414243_tx", 64'(txC), 64'(expC));
      checkOutput("frames_irq_stop", 64'(irqC63), 64'(1'b0));
      checkOutput("frames_irq_idle", 64'(irqC64), 64'(1'b1));

      // Overflow with the transmitter disabled
      busWrite(A_CTRL, 32'h0);
      for (int k = 0; k < 9; k++) busWrite(A_TXDATA, 32'(k + 1));
      busRead(A_STATUS, rd);
      checkOutput("status_overflow", 64'(rd), 64'h80A);
      checkOutput("irq_disabled", 64'(irq), 64'(1'b0));
      checkOutput("tx_disabled_idle", 64'(tx), 64'(1'b1));
      busWrite(A_CTRL, 32'h3);
      busRead(A_STATUS, rd);
      checkOutput("status_ovf_cleared", 64'(rd), 64'h802);
      busWrite(A_TXDATA, 32'hAA);
      busRead(A_STATUS, rd);
      checkOutput("status_push_pop_full", 64'(rd), 64'h803);

      // Reset in the middle of data bit 1 of byte 0x01
      repeat (4) @(negedge clk);
      #1;
      checkOutput("tx_data_bit1", 64'(tx), 64'(1'b0));
      rst = 1'b0;
      #1;
      checkOutput("tx_async_reset", 64'(tx), 64'(1'b1));
      checkOutput("irq_async_reset", 64'(irq), 64'(1'b0));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      busRead(A_STATUS, rd);
      checkOutput("status_after_reset", 64'(rd), 64'h4);
      busRead(A_CLKDIV, rd);
      checkOutput("clkdiv_after_reset", 64'(rd), 64'd867);
      allHigh = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         allHigh = allHigh & tx;
      end
      checkOutput("no_residual_frame", 64'(allHigh), 64'(1'b1));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
